// File: rtl/mac_accum.sv
// MAC-and-accumulate stage: Q-format multiply feeding a per-address accumulator file.
// Optional MAC_SATURATE_EN saturates product and sum and drives a sticky ovf flag.
module mac_accum #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = 8,
  parameter int unsigned ACT_NO     = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  comp_en_mac,
  input  logic [DATA_WIDTH-1:0] in_act_value_mac,
  input  logic [DATA_WIDTH-1:0] w_value_mac,
  input  logic [ADDR_WIDTH-1:0] out_act_addr_mac,
  input  logic                  acc_clear,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  ovf
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         act_ext;
  logic [PW-1:0]         w_ext;
  logic [PW-1:0]         prod_full;
  logic [DATA_WIDTH-1:0] prod_c;
  logic [DATA_WIDTH-1:0] prod_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mul_vld;
  logic                  acc_vld;
  logic [DATA_WIDTH-1:0] acc [ACT_NO];
  logic [DATA_WIDTH-1:0] acc_rd_c;
  logic [DATA_WIDTH-1:0] sum_c;

  // Full-width signed product; operands sign-extended so the low PW bits are exact.
  always_comb begin
    act_ext   = {{DATA_WIDTH{in_act_value_mac[DATA_WIDTH-1]}}, in_act_value_mac};
    w_ext     = {{DATA_WIDTH{w_value_mac[DATA_WIDTH-1]}}, w_value_mac};
    prod_full = act_ext * w_ext;
  end

  assign acc_rd_c = acc[addr_q];

`ifdef MAC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [PW-1:0]       prod_shift;
  logic                prod_sat_c;
  logic                prod_sat_q;
  logic [DATA_WIDTH:0] sum_ext;
  logic                sum_sat_c;

  // Product fits only if every bit above the result's sign bit matches it.
  always_comb begin
    prod_shift = PW'($signed(prod_full) >>> FRAC_WIDTH);
    prod_sat_c = !((&prod_shift[PW-1:DATA_WIDTH-1]) || !(|prod_shift[PW-1:DATA_WIDTH-1]));
    prod_c     = prod_shift[DATA_WIDTH-1:0];
    if (prod_sat_c) begin
      prod_c = prod_shift[PW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    sum_ext   = {acc_rd_c[DATA_WIDTH-1], acc_rd_c} + {prod_q[DATA_WIDTH-1], prod_q};
    sum_sat_c = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
    sum_c     = sum_ext[DATA_WIDTH-1:0];
    if (sum_sat_c) begin
      sum_c = sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_sat_q <= 1'b0;
    end else if (comp_en_mac && !acc_clear) begin
      prod_sat_q <= prod_sat_c;
    end
  end

  // Sticky until clear or reset; a saturation seen in a cleared ACC cycle is discarded too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (acc_clear) begin
      ovf <= 1'b0;
    end else if (mul_vld && (prod_sat_q || sum_sat_c)) begin
      ovf <= 1'b1;
    end
  end
`else
  always_comb begin
    prod_c = DATA_WIDTH'($signed(prod_full) >>> FRAC_WIDTH);
    sum_c  = acc_rd_c + prod_q;
  end

  assign ovf = 1'b0;
`endif

  // MUL stage register and valid pipeline; busy is registered from next-state valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      addr_q  <= '0;
      mul_vld <= 1'b0;
      acc_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      mul_vld <= comp_en_mac && !acc_clear;
      acc_vld <= mul_vld && !acc_clear;
      busy    <= (comp_en_mac || mul_vld) && !acc_clear;
      if (comp_en_mac && !acc_clear) begin
        prod_q <= prod_c;
        addr_q <= out_act_addr_mac;
      end
    end
  end

  // Accumulator file: read-modify-write in one cycle, clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ACT_NO; i++) begin
        acc[i] <= '0;
      end
    end else if (acc_clear) begin
      for (int unsigned i = 0; i < ACT_NO; i++) begin
        acc[i] <= '0;
      end
    end else if (mul_vld) begin
      acc[addr_q] <= sum_c;
    end
  end

  // Read port sees the array before this edge's write or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= acc[rd_addr];
      end
    end
  end

endmodule
